// File: rtl/fft_frame_serializer.sv
// -----------------------------------------------------------------------------
// fft_frame_serializer
//
// Output-side consumer of the parallel FFT butterfly datapath. A whole N-point
// complex frame is captured in one handshake. The frame arrives in bit-reversed
// bin order, as radix-2 DIF stages produce it. The block then streams it out one
// bin per beat, in natural bin order, over a valid/ready interface.
//
// There are two frame banks used as a ping-pong pair. The next frame can be
// captured while the current one drains. Data passes through unmodified.
//
// Parameters
//   N       points per frame (power of 2, >= 2)
//   DW      bits per real/imag component (two's complement)
//   BITREV  1: beat k carries input slot bitrev(k); 0: beat k carries slot k
//
// Ports
//   clk_i           in   clock, all logic on the rising edge
//   reset_i         in   synchronous reset, active-high
//   frame_i         in   N slots of {re[2*DW-1:DW], im[DW-1:0]}
//   frame_valid_i   in   frame_i is valid
//   frame_ready_o   out  a frame can be captured this cycle
//   sample_o        out  current bin, {re, im}
//   sample_idx_o    out  natural bin index of sample_o
//   sample_valid_o  out  sample_o / sample_idx_o / sample_last_o are valid
//   sample_ready_i  in   downstream accepts the beat
//   sample_last_o   out  high on beat N-1 of each frame
// -----------------------------------------------------------------------------
module fft_frame_serializer #(
    parameter int N      = 8,
    parameter int DW     = 44,
    parameter bit BITREV = 1'b1
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic [N-1:0][2*DW-1:0] frame_i,
    input  logic                   frame_valid_i,
    output logic                   frame_ready_o,
    output logic [2*DW-1:0]        sample_o,
    output logic [$clog2(N)-1:0]   sample_idx_o,
    output logic                   sample_valid_o,
    input  logic                   sample_ready_i,
    output logic                   sample_last_o
);

    localparam int            IW       = $clog2(N);
    localparam int            SW       = 2 * DW;
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    typedef logic [N-1:0][SW-1:0] frame_t;

    // Catch illegal frame sizes at elaboration rather than producing a
    // silently wrong bin ordering.
    if (N < 2 || (N & (N - 1)) != 0) begin : g_bad_n
        $error("fft_frame_serializer: N must be a power of 2 and >= 2");
    end

    // Mirror the IW-bit index: bit b of the result is bit IW-1-b of k.
    function automatic logic [IW-1:0] bitrev(input logic [IW-1:0] k);
        logic [IW-1:0] r;
        for (int b = 0; b < IW; b++) begin
            r[b] = k[IW-1-b];
        end
        return r;
    endfunction

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    frame_t        bank_q [2];
    logic [1:0]    full_q,    full_d;
    logic          wr_bank_q, wr_bank_d;
    logic          rd_bank_q, rd_bank_d;
    logic [IW-1:0] rd_cnt_q,  rd_cnt_d;

    // -------------------------------------------------------------------------
    // Handshake decode
    // -------------------------------------------------------------------------
    logic          capture;    // frame accepted at this edge
    logic          out_valid;  // a beat is presented this cycle
    logic          beat;       // a beat transfers at this edge
    logic          last_beat;  // the final beat of the head frame transfers
    logic [IW-1:0] rd_slot;    // storage slot feeding the current beat

    // Readiness depends only on the write-side full flag. The drain side
    // never makes a bank writable within the cycle it is freed.
    assign frame_ready_o = !reset_i && !full_q[wr_bank_q];
    assign capture       = frame_valid_i && frame_ready_o;

    assign out_valid = !reset_i && full_q[rd_bank_q];
    assign beat      = out_valid && sample_ready_i;
    assign last_beat = beat && (rd_cnt_q == LAST_IDX);

    assign rd_slot = BITREV ? bitrev(rd_cnt_q) : rd_cnt_q;

    // -------------------------------------------------------------------------
    // Output stage
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first, so no branch
        // leaves one unassigned. An unassigned branch would infer a latch.
        sample_valid_o = 1'b0;
        sample_o       = '0;
        sample_idx_o   = '0;
        sample_last_o  = 1'b0;
        if (out_valid) begin
            sample_valid_o = 1'b1;
            sample_o       = bank_q[rd_bank_q][rd_slot];
            sample_idx_o   = rd_cnt_q;
            sample_last_o  = (rd_cnt_q == LAST_IDX);
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        full_d    = full_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        rd_cnt_d  = rd_cnt_q;

        // Capture and drain touch different banks. A capture needs its bank
        // empty and a drain needs its bank full, so both can apply together.
        if (capture) begin
            full_d[wr_bank_q] = 1'b1;
            wr_bank_d         = !wr_bank_q;
        end

        if (beat) begin
            if (last_beat) begin
                rd_cnt_d          = '0;
                full_d[rd_bank_q] = 1'b0;
                rd_bank_d         = !rd_bank_q;
            end else begin
                rd_cnt_d = rd_cnt_q + 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Control registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        // NOTE: non-blocking assignments, so every register here is updated
        // from pre-edge values regardless of statement order.
        if (reset_i) begin
            full_q    <= '0;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            rd_cnt_q  <= '0;
        end else begin
            full_q    <= full_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            rd_cnt_q  <= rd_cnt_d;
        end
    end

    // -------------------------------------------------------------------------
    // Frame storage
    // -------------------------------------------------------------------------
    // NOTE: bank contents are not reset. full_q alone decides whether a bank
    // holds meaningful data, and leaving the array unreset lets it map onto
    // plain enable flops or RAM.
    always_ff @(posedge clk_i) begin
        if (capture) begin
            bank_q[wr_bank_q] <= frame_i;
        end
    end

endmodule

// File: tb/tb_fft_frame_serializer.sv
// -----------------------------------------------------------------------------
// tb_fft_frame_serializer
//
// Two instances run side by side on identical stimulus, one with BITREV=1 and
// one with BITREV=0. The reference model treats the block as a FIFO of at
// most two whole frames plus a beat position in the head frame. The expected
// bin for beat k is slot REV[k] (or slot k) of the head frame.
// -----------------------------------------------------------------------------
module tb_fft_frame_serializer;

    localparam int N  = 8;
    localparam int DW = 44;
    localparam int IW = 3;
    localparam int SW = 2 * DW;

    typedef logic [N-1:0][SW-1:0] frame_t;

    typedef struct {
        bit fv;         // frame_valid_i for this cycle (frame = ramp)
        bit rdy;        // sample_ready_i for this cycle
        bit exp_valid;
        int exp_idx;
        bit exp_last;
    } vec_t;

    // Bit-reversed order of 0..7
    int rev_tbl [N] = '{0, 4, 2, 6, 1, 5, 3, 7};

    logic          clk_i = 1'b0;
    logic          reset_in = 1'b0;
    frame_t        frame_in = '0;
    logic          frame_valid_in = 1'b0;
    logic          sample_ready_in = 1'b0;

    logic          br_ready, br_valid, br_last;
    logic [SW-1:0] br_sample;
    logic [IW-1:0] br_idx;
    logic          nr_ready, nr_valid, nr_last;
    logic [SW-1:0] nr_sample;
    logic [IW-1:0] nr_idx;

    always #5 clk_i = ~clk_i;

    fft_frame_serializer #(.N(N), .DW(DW), .BITREV(1'b1)) dut_br (
        .clk_i          (clk_i),
        .reset_i        (reset_in),
        .frame_i        (frame_in),
        .frame_valid_i  (frame_valid_in),
        .frame_ready_o  (br_ready),
        .sample_o       (br_sample),
        .sample_idx_o   (br_idx),
        .sample_valid_o (br_valid),
        .sample_ready_i (sample_ready_in),
        .sample_last_o  (br_last)
    );

    fft_frame_serializer #(.N(N), .DW(DW), .BITREV(1'b0)) dut_nr (
        .clk_i          (clk_i),
        .reset_i        (reset_in),
        .frame_i        (frame_in),
        .frame_valid_i  (frame_valid_in),
        .frame_ready_o  (nr_ready),
        .sample_o       (nr_sample),
        .sample_idx_o   (nr_idx),
        .sample_valid_o (nr_valid),
        .sample_ready_i (sample_ready_in),
        .sample_last_o  (nr_last)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: frames waiting or draining, and the beat position
    // within the head frame.
    frame_t mq [$];
    int     m_beat = 0;

    // Observed outputs, sampled mid-cycle by run_cycle
    logic          obs_br_ready, obs_br_valid, obs_br_last;
    logic [SW-1:0] obs_br_sample;
    logic [IW-1:0] obs_br_idx;
    logic          obs_nr_valid, obs_nr_last;
    logic [SW-1:0] obs_nr_sample;
    logic [IW-1:0] obs_nr_idx;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic frame_t ramp_frame();
        frame_t f;
        for (int s = 0; s < N; s++) f[s] = {DW'(s), DW'(-s)};
        return f;
    endfunction

    function automatic frame_t rand_frame();
        frame_t f;
        for (int s = 0; s < N; s++) f[s] = SW'({$urandom(), $urandom(), $urandom()});
        return f;
    endfunction

    function automatic logic [SW-1:0] ramp_slot(input int s);
        return {DW'(s), DW'(-s)};
    endfunction

    // Called at posedge+1 with inputs already set. Samples at the falling
    // edge, compares against the model, then advances the model at the edge.
    task automatic run_cycle();
        bit            e_ready, e_valid, e_last;
        logic [IW-1:0] e_idx;
        logic [SW-1:0] e_br, e_nr;
        #4;
        obs_br_ready  = br_ready;
        obs_br_valid  = br_valid;
        obs_br_sample = br_sample;
        obs_br_idx    = br_idx;
        obs_br_last   = br_last;
        obs_nr_valid  = nr_valid;
        obs_nr_sample = nr_sample;
        obs_nr_idx    = nr_idx;
        obs_nr_last   = nr_last;

        e_ready = !reset_in && (mq.size() < 2);
        e_valid = !reset_in && (mq.size() > 0);
        e_idx = '0; e_br = '0; e_nr = '0; e_last = 1'b0;
        if (e_valid) begin
            e_idx  = IW'(m_beat);
            e_br   = mq[0][rev_tbl[m_beat]];
            e_nr   = mq[0][m_beat];
            e_last = (m_beat == N - 1);
        end
        check("model_br_ready",  128'(br_ready),  128'(e_ready));
        check("model_br_valid",  128'(br_valid),  128'(e_valid));
        check("model_br_idx",    128'(br_idx),    128'(e_idx));
        check("model_br_sample", 128'(br_sample), 128'(e_br));
        check("model_br_last",   128'(br_last),   128'(e_last));
        check("model_nr_ready",  128'(nr_ready),  128'(e_ready));
        check("model_nr_valid",  128'(nr_valid),  128'(e_valid));
        check("model_nr_idx",    128'(nr_idx),    128'(e_idx));
        check("model_nr_sample", 128'(nr_sample), 128'(e_nr));
        check("model_nr_last",   128'(nr_last),   128'(e_last));

        @(posedge clk_i);
        if (reset_in) begin
            mq.delete();
            m_beat = 0;
        end else begin
            if (e_valid && sample_ready_in) begin
                if (m_beat == N - 1) begin
                    m_beat = 0;
                    void'(mq.pop_front());
                end else begin
                    m_beat++;
                end
            end
            if (frame_valid_in && e_ready) mq.push_back(frame_in);
        end
        #1;
    endtask

    task automatic do_reset();
        reset_in        = 1'b1;
        frame_valid_in  = 1'b0;
        sample_ready_in = 1'b0;
        run_cycle();
        run_cycle();
        reset_in = 1'b0;
    endtask

    vec_t   vecs [$];
    frame_t offers [3];
    frame_t fa, fb, fd;
    int     cap_cyc [3];
    int     oi, ready_lo, vcnt, rlo_bad, hold_bad;
    bit     v0, v25;
    int     stall_rdy [11] = '{1, 1, 0, 0, 0, 1, 1, 1, 1, 1, 1};
    int     stall_idx [11] = '{0, 1, 2, 2, 2, 2, 3, 4, 5, 6, 7};

    initial begin
        // ---------------- vector table: plain frame, then stalled frame -----
        vecs.push_back('{1, 0, 0, 0, 0});
        for (int k = 0; k < N; k++) vecs.push_back('{0, 1, 1, k, k == N - 1});
        vecs.push_back('{1, 0, 0, 0, 0});
        for (int r = 0; r < 11; r++)
            vecs.push_back('{0, stall_rdy[r] != 0, 1, stall_idx[r], r == 10});

        @(posedge clk_i);
        #1;

        // ---------------- table-driven: ramp frame, both orderings ----------
        do_reset();
        frame_in = ramp_frame();
        foreach (vecs[i]) begin
            frame_valid_in  = vecs[i].fv;
            sample_ready_in = vecs[i].rdy;
            run_cycle();
            check("tbl_br_valid", 128'(obs_br_valid), 128'(vecs[i].exp_valid));
            check("tbl_nr_valid", 128'(obs_nr_valid), 128'(vecs[i].exp_valid));
            if (vecs[i].exp_valid) begin
                check("tbl_br_idx",    128'(obs_br_idx),    128'(vecs[i].exp_idx));
                check("tbl_nr_idx",    128'(obs_nr_idx),    128'(vecs[i].exp_idx));
                check("tbl_br_sample", 128'(obs_br_sample),
                      128'(ramp_slot(rev_tbl[vecs[i].exp_idx])));
                check("tbl_nr_sample", 128'(obs_nr_sample), 128'(ramp_slot(vecs[i].exp_idx)));
                check("tbl_br_last",   128'(obs_br_last),   128'(vecs[i].exp_last));
                check("tbl_nr_last",   128'(obs_nr_last),   128'(vecs[i].exp_last));
            end
        end
        frame_valid_in = 1'b0;

        // ---------------- back-to-back frames A, B, C ------------------------
        do_reset();
        for (int i = 0; i < 3; i++) begin
            offers[i]  = rand_frame();
            cap_cyc[i] = -1;
        end
        oi = 0; ready_lo = 0; vcnt = 0; v0 = 1'b1; v25 = 1'b1;
        sample_ready_in = 1'b1;
        for (int c = 0; c < 27; c++) begin
            frame_valid_in = (oi < 3);
            frame_in       = (oi < 3) ? offers[oi] : rand_frame();
            run_cycle();
            if (frame_valid_in && obs_br_ready) begin
                cap_cyc[oi] = c;
                oi++;
            end
            if (c >= 2 && c <= 8 && !obs_br_ready) ready_lo++;
            if (c >= 1 && c <= 24 && obs_br_valid) vcnt++;
            if (c == 0)  v0  = obs_br_valid;
            if (c == 25) v25 = obs_br_valid;
        end
        check("b2b_cap_a",      128'(cap_cyc[0]), 128'(0));
        check("b2b_cap_b",      128'(cap_cyc[1]), 128'(1));
        check("b2b_cap_c",      128'(cap_cyc[2]), 128'(9));
        check("b2b_ready_low",  128'(ready_lo),   128'(7));
        check("b2b_beats",      128'(vcnt),       128'(24));
        check("b2b_valid_c0",   128'(v0),         128'(0));
        check("b2b_valid_c25",  128'(v25),        128'(0));
        frame_valid_in = 1'b0;

        // ---------------- reset mid-frame with B buffered --------------------
        do_reset();
        fa = rand_frame(); fb = rand_frame(); fd = rand_frame();
        sample_ready_in = 1'b1;
        frame_valid_in = 1'b1; frame_in = fa; run_cycle();
        frame_in = fb; run_cycle();
        frame_valid_in = 1'b0; run_cycle();
        run_cycle();
        check("rst_pre_idx", 128'(obs_br_idx), 128'(2));
        reset_in = 1'b1; run_cycle();
        check("rst_valid_in_reset", 128'(obs_br_valid), 128'(0));
        check("rst_ready_in_reset", 128'(obs_br_ready), 128'(0));
        reset_in = 1'b0; run_cycle();
        check("rst_ready_after", 128'(obs_br_ready), 128'(1));
        check("rst_valid_after", 128'(obs_br_valid), 128'(0));
        frame_valid_in = 1'b1; frame_in = fd; run_cycle();
        frame_valid_in = 1'b0;
        for (int k = 0; k < N; k++) begin
            run_cycle();
            check("rst_d_idx",    128'(obs_br_idx),    128'(k));
            check("rst_d_sample", 128'(obs_br_sample), 128'(fd[rev_tbl[k]]));
        end
        run_cycle();
        check("rst_no_residue", 128'(obs_br_valid), 128'(0));

        // ---------------- full backpressure, three frames offered ------------
        do_reset();
        for (int i = 0; i < 3; i++) offers[i] = rand_frame();
        oi = 0; rlo_bad = 0; hold_bad = 0;
        sample_ready_in = 1'b0;
        for (int c = 0; c < 12; c++) begin
            frame_valid_in = (oi < 3);
            frame_in       = (oi < 3) ? offers[oi] : rand_frame();
            run_cycle();
            if (frame_valid_in && obs_br_ready) oi++;
            if (c >= 2 && obs_br_ready) rlo_bad++;
            if (c >= 1 && (obs_br_sample !== offers[0][0] || obs_br_idx !== '0 || !obs_br_valid))
                hold_bad++;
        end
        check("bp_captured",   128'(oi),       128'(2));
        check("bp_ready_low",  128'(rlo_bad),  128'(0));
        check("bp_beat0_hold", 128'(hold_bad), 128'(0));
        frame_valid_in  = 1'b0;
        sample_ready_in = 1'b1;
        for (int c = 0; c < 20; c++) run_cycle();

        // ---------------- randomized traffic against the model ---------------
        do_reset();
        for (int c = 0; c < 800; c++) begin
            reset_in        = ($urandom_range(0, 63) == 0);
            frame_valid_in  = ($urandom_range(0, 1) == 1);
            sample_ready_in = ($urandom_range(0, 3) != 0);
            frame_in        = rand_frame();
            run_cycle();
        end
        reset_in = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
